// File: rtl/branch_tag_manager.sv
// Branch tag allocator: hands out {colour, id} tags in age order, retires them
// in order as they resolve, and rewinds the tail on a mispredict.
module branch_tag_manager #(
    parameter int NUM_TAGS = 8,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_grant,
    output logic [TAG_W-1:0] alloc_id,
    output logic             alloc_color,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_id,
    input  logic             resolve_color,
    input  logic             resolve_miss,
    output logic             full,
    output logic             empty,
    output logic [TAG_W:0]   count,
    output logic             squash_valid,
    output logic [TAG_W-1:0] squash_id,
    output logic             squash_color,
    output logic             err_stale
);

    localparam int PW = TAG_W + 1;

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [NUM_TAGS-1:0] resolved_q, resolved_d;
    logic                squash_valid_q, squash_valid_d;
    logic [TAG_W-1:0]    squash_id_q, squash_id_d;
    logic                squash_color_q, squash_color_d;
    logic                err_stale_q, err_stale_d;

    logic [PW-1:0] resolve_ptr;
    logic [PW-1:0] resolve_off;
    logic          in_window;
    logic          mispredict;
    logic          retire;

    // Pointer difference wraps modulo 2*NUM_TAGS, so the colour bit keeps
    // a full window distinguishable from an empty one.
    assign count       = tail_q - head_q;
    assign full        = (count == PW'(NUM_TAGS));
    assign empty       = (count == '0);
    assign resolve_ptr = {resolve_color, resolve_id};
    assign resolve_off = resolve_ptr - head_q;
    assign in_window   = (resolve_off < count);
    assign mispredict  = resolve_valid & resolve_miss & in_window;
    assign retire      = resolved_q[head_q[TAG_W-1:0]] & ~empty;

    // Handshake: alloc_req is a request held by decode; alloc_grant is the
    // same-cycle acceptance, and a tag is consumed only when both are high.
    assign alloc_grant = alloc_req & ~full & ~mispredict;
    assign alloc_id    = tail_q[TAG_W-1:0];
    assign alloc_color = tail_q[TAG_W];

    assign squash_valid = squash_valid_q;
    assign squash_id    = squash_id_q;
    assign squash_color = squash_color_q;
    assign err_stale    = err_stale_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        resolved_d     = resolved_q;
        squash_valid_d = mispredict;
        squash_id_d    = squash_id_q;
        squash_color_d = squash_color_q;
        err_stale_d    = err_stale_q;

        if (resolve_valid) begin
            if (in_window) begin
                resolved_d[resolve_id] = 1'b1;
            end else begin
                err_stale_d = 1'b1;
            end
        end

        if (mispredict) begin
            tail_d         = resolve_ptr + PW'(1);
            squash_id_d    = resolve_id;
            squash_color_d = resolve_color;
        end

        // Retire uses the registered resolved bit, so it lags a resolve by a cycle.
        if (retire) begin
            head_d                          = head_q + PW'(1);
            resolved_d[head_q[TAG_W-1:0]]   = 1'b0;
        end

        if (alloc_grant) begin
            tail_d                          = tail_q + PW'(1);
            resolved_d[tail_q[TAG_W-1:0]]   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            resolved_q     <= '0;
            squash_valid_q <= 1'b0;
            squash_id_q    <= '0;
            squash_color_q <= 1'b0;
            err_stale_q    <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            resolved_q     <= resolved_d;
            squash_valid_q <= squash_valid_d;
            squash_id_q    <= squash_id_d;
            squash_color_q <= squash_color_d;
            err_stale_q    <= err_stale_d;
        end
    end

endmodule

// File: tb/tb_branch_tag_manager.sv
// Bench for branch_tag_manager: directed scenarios then random traffic, all
// checked against a queue-of-tags model of the in-flight window.
module tb_branch_tag_manager;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_grant;
    logic [2:0] alloc_id;
    logic       alloc_color;
    logic       resolve_valid;
    logic [2:0] resolve_id;
    logic       resolve_color;
    logic       resolve_miss;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       squash_valid;
    logic [2:0] squash_id;
    logic       squash_color;
    logic       err_stale;

    int checks = 0;
    int errors = 0;

    // Model: in-flight tags oldest first, as plain 0..15 values ({colour,id}).
    int q_tag[$];
    bit q_res[$];
    int m_tail = 0;
    bit m_err = 0;
    bit m_sq_v = 0;
    int m_sq_p = 0;

    branch_tag_manager #(.NUM_TAGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_grant(alloc_grant),
        .alloc_id(alloc_id), .alloc_color(alloc_color),
        .resolve_valid(resolve_valid), .resolve_id(resolve_id),
        .resolve_color(resolve_color), .resolve_miss(resolve_miss),
        .full(full), .empty(empty), .count(count),
        .squash_valid(squash_valid), .squash_id(squash_id),
        .squash_color(squash_color), .err_stale(err_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_tag.delete();
        q_res.delete();
        m_tail = 0;
        m_err  = 0;
        m_sq_v = 0;
        m_sq_p = 0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update model, check state.
    task automatic step(input bit a, input bit rv, input int p, input bit miss);
        int  idx;
        bit  exp_grant;
        bit  do_retire;
        logic [3:0] pv;
        pv = 4'(p);
        alloc_req     = a;
        resolve_valid = rv;
        resolve_id    = pv[2:0];
        resolve_color = pv[3];
        resolve_miss  = miss;
        #1;
        idx = -1;
        foreach (q_tag[i]) if (q_tag[i] == p) idx = i;
        exp_grant = a && (q_tag.size() < 8) && !(rv && miss && idx >= 0);
        chk("alloc_grant", alloc_grant, exp_grant);
        if (exp_grant) begin
            chk("alloc_id", alloc_id, m_tail % 8);
            chk("alloc_color", alloc_color, m_tail / 8);
        end
        chk("count_pre", count, q_tag.size());
        chk("full", full, q_tag.size() == 8);
        chk("empty", empty, q_tag.size() == 0);
        @(posedge clk);
        do_retire = (q_tag.size() > 0) && q_res[0];
        m_sq_v = 0;
        if (rv && idx >= 0) begin
            q_res[idx] = 1;
            if (miss) begin
                while (q_tag.size() > idx + 1) begin
                    void'(q_tag.pop_back());
                    void'(q_res.pop_back());
                end
                m_tail = (p + 1) % 16;
                m_sq_v = 1;
                m_sq_p = p;
            end
        end else if (rv) begin
            m_err = 1;
        end
        if (do_retire) begin
            void'(q_tag.pop_front());
            void'(q_res.pop_front());
        end
        if (exp_grant) begin
            q_tag.push_back(m_tail);
            q_res.push_back(0);
            m_tail = (m_tail + 1) % 16;
        end
        #1;
        chk("count_post", count, q_tag.size());
        chk("squash_valid", squash_valid, m_sq_v);
        if (m_sq_v) begin
            chk("squash_id", squash_id, m_sq_p % 8);
            chk("squash_color", squash_color, m_sq_p / 8);
        end
        chk("err_stale", err_stale, m_err);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        alloc_req     = 0;
        resolve_valid = 0;
        resolve_miss  = 0;
        #2;
        rst_n = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_grant", alloc_grant, 0);
        chk("rst_squash_valid", squash_valid, 0);
        chk("rst_squash_id", squash_id, 0);
        chk("rst_err_stale", err_stale, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_clear();
    endtask

    initial begin
        int p;
        rst_n = 1;
        alloc_req = 0; resolve_valid = 0; resolve_id = 0; resolve_color = 0; resolve_miss = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Fill to full, then a ninth request is refused.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        chk("full_after_8", full, 1);
        step(1, 0, 0, 0);
        // Resolve oldest; it retires a cycle later, then the freed slot comes back as colour 1.
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("wrap_tail", m_tail, 9);

        // Mispredict on id2 with tags 0..5 live and a same-cycle alloc request.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        step(1, 1, 2, 1);
        chk("squash_count", count, 3);
        step(0, 0, 0, 0);

        // Out-of-order resolves retire in age order.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ooo_empty", empty, 1);

        // Wrong-colour resolve is stale.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 1, 8 + 3, 1);
        chk("stale_flag", err_stale, 1);

        // Reset with five tags in flight, then a resolve of a dropped tag.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        do_reset();
        step(0, 1, 0, 0);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 150 == 149) do_reset();
            if (q_tag.size() > 0 && $urandom_range(0, 9) < 6)
                p = q_tag[$urandom_range(0, q_tag.size() - 1)];
            else
                p = $urandom_range(0, 15);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5, p, $urandom_range(0, 9) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
